fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h4000_0060, the PC fetched first after reset.
REQ-002 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The module SHALL have port imem_address  output  32  fetch address, word-aligned.
REQ-005 The module SHALL have port imem_read  output  1  read request, held with a stable address until imem_resp.
REQ-006 The module SHALL have port imem_rdata  input  32  instruction word, valid when imem_resp=1.
REQ-007 The module SHALL have port imem_resp  input  1  single-cycle read-completion pulse.
REQ-008 The module SHALL have port stall_id  input  1  decode cannot accept; the IF/ID contents are held.
REQ-009 The module SHALL have port flush  input  1  redirect request; has priority over stall_id.
REQ-010 The module SHALL have port redirect_pc  input  32  new fetch PC, sampled when flush=1.
REQ-011 The module SHALL have port id_valid  output  1  IF/ID register holds a live instruction.
REQ-012 The module SHALL have port id_pc  output  32  PC of id_instr.
REQ-013 The module SHALL have port id_instr  output  32  instruction word feeding the decode field extractor.

Function
REQ-014 The module SHALL allow one outstanding memory request and no more.
REQ-015 The module SHALL define a transfer as id_valid=1 and stall_id=0 in the same cycle.
REQ-016 The module SHALL have registers pc (next fetch PC), req_addr (driven on imem_address), the IF/ID registers, and a 1-entry skid buffer (buf_valid, buf_pc, buf_instr).
REQ-017 The module SHALL implement states FETCH (imem_read=1), WAIT_SLOT (imem_read=0), and DRAIN (imem_read=1 at the stale req_addr).
REQ-018 In FETCH, when imem_resp=1 and flush=0, the word SHALL load IF/ID if id_valid=0 or a transfer occurs; otherwise it SHALL load the skid buffer.
REQ-019 On an accepted response, pc SHALL become req_addr+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-020 After an accepted response, the next state SHALL be WAIT_SLOT if the buffer is (or becomes) full, else FETCH with imem_address=req_addr+4 on the next cycle.
REQ-021 Latency SHALL be: imem_resp in cycle N gives id_valid=1 with that word in cycle N+1 when the slot is free.
REQ-022 On a transfer with buf_valid=1, the buffer SHALL move into IF/ID and buf_valid SHALL clear; program order SHALL be preserved.
REQ-023 On a transfer with buf_valid=0 and no incoming word, id_valid SHALL clear.
REQ-024 WAIT_SLOT SHALL return to FETCH the cycle after buf_valid clears.
REQ-025 When stall_id=1 and no transfer occurs, id_valid, id_pc and id_instr SHALL hold.
REQ-026 Flush SHALL, in the same edge, clear id_valid and buf_valid and set pc=redirect_pc.
REQ-027 Flush with a request outstanding and no imem_resp SHALL enter DRAIN.
REQ-028 DRAIN SHALL hold imem_read and the old address until imem_resp, discard that word, then enter FETCH at pc.
REQ-029 Flush coincident with imem_resp SHALL discard the word and request redirect_pc the next cycle.
REQ-030 Flush in DRAIN SHALL update pc only.
REQ-031 Flush in WAIT_SLOT SHALL enter FETCH at redirect_pc.
REQ-032 redirect_pc[1:0] SHALL be ignored, treated as 2'b00.

Reset
REQ-033 While rst=1, the module SHALL set pc=req_addr=RESET_PC, state=FETCH, id_valid=0, id_pc=0, id_instr=32'h0000_0013, buf_valid=0, and imem_read=0.
REQ-034 imem_read SHALL first assert in the cycle after rst falls, with imem_address=RESET_PC.
REQ-035 rst mid-request SHALL abandon the outstanding request; a late imem_resp SHALL be ignored only if it arrives while rst=1.

Verification
REQ-036 The bench SHALL cover: reset then resp of 32'h00A00093 on every fetch with stall_id=0 -> id_pc 4000_0060, 4000_0064, 4000_0068 on consecutive responses, id_valid each cycle after a resp.
REQ-037 The bench SHALL cover: stall_id=1 for 5 cycles while two responses arrive -> IF/ID holds the first word, the second goes to the buffer, imem_read=0 in WAIT_SLOT; after release both words emerge in order.
REQ-038 The bench SHALL cover: flush with redirect_pc=32'h4000_1000 while a request at 4000_0068 is outstanding -> DRAIN, that resp discarded, next imem_address=4000_1000, id_valid=0 until its resp.
REQ-039 The bench SHALL cover: flush coincident with imem_resp -> word dropped; imem_address=redirect_pc on the next cycle.
REQ-040 The bench SHALL cover: RESET_PC=32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
REQ-041 The bench SHALL cover: flush and stall_id together with buffer full -> id_valid=0 and buf_valid=0 next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: a single outstanding imem read, the IF/ID register and a
// one-entry skid buffer. Redirects wait for any in-flight read to return before refetching.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall_id,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  // state     | meaning
  // S_FETCH   | read outstanding at req_addr; a response is accepted
  // S_WAIT    | IF/ID and skid buffer both full; no read issued
  // S_DRAIN   | redirected; waiting out a stale read whose word is dropped
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        transfer;
  logic [31:0] redir_pc;

  assign transfer = id_valid_q & ~stall_id;
  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      id_valid_q  <= 1'b0;
      id_pc_q     <= 32'h0;
      id_instr_q  <= NOP;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_instr_q <= NOP;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    id_valid_d  = id_valid_q;
    id_pc_d     = id_pc_q;
    id_instr_d  = id_instr_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;

    // Decode takes IF/ID; refill from the skid buffer first to keep program order.
    if (transfer) begin
      if (buf_valid_q) begin
        id_pc_d     = buf_pc_q;
        id_instr_d  = buf_instr_q;
        buf_valid_d = 1'b0;
      end else begin
        id_valid_d = 1'b0;
      end
    end

    case (state_q)
      S_FETCH: begin
        if (imem_resp && !flush) begin
          pc_d = req_addr_q + 32'd4;
          if (!id_valid_d) begin
            id_valid_d = 1'b1;
            id_pc_d    = req_addr_q;
            id_instr_d = imem_rdata;
          end else begin
            buf_valid_d = 1'b1;
            buf_pc_d    = req_addr_q;
            buf_instr_d = imem_rdata;
          end
          if (buf_valid_d) state_d = S_WAIT;
          else req_addr_d = pc_d;
        end
      end
      S_WAIT: begin
        if (!buf_valid_d) begin
          state_d    = S_FETCH;
          req_addr_d = pc_q;
        end
      end
      S_DRAIN: begin
        if (imem_resp) begin
          state_d    = S_FETCH;
          req_addr_d = pc_q;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Redirect overrides everything above; a live read must still be drained.
    if (flush) begin
      pc_d = redir_pc;
      if (state_q != S_DRAIN) begin
        id_valid_d  = 1'b0;
        buf_valid_d = 1'b0;
      end
      if (state_q == S_WAIT || imem_resp) begin
        state_d    = S_FETCH;
        req_addr_d = redir_pc;
      end else begin
        state_d    = S_DRAIN;
        req_addr_d = req_addr_q;
      end
    end
  end

  assign imem_read    = ~rst & (state_q != S_WAIT);
  assign imem_address = req_addr_q;
  assign id_valid     = id_valid_q;
  assign id_pc        = id_pc_q;
  assign id_instr     = id_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Cycle table for fetch_unit: each row drives one cycle's inputs and lists the
// outputs expected in that cycle; a second instance covers the PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_resp = 1'b0;
  logic        stall_id = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic [31:0] imem_address, w_address;
  logic        imem_read, w_read;
  logic        id_valid, w_valid;
  logic [31:0] id_pc, w_pc, id_instr, w_instr;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_address(imem_address), .imem_read(imem_read),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp), .stall_id(stall_id), .flush(flush),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .imem_address(w_address), .imem_read(w_read),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp), .stall_id(stall_id), .flush(flush),
    .redirect_pc(redirect_pc), .id_valid(w_valid), .id_pc(w_pc), .id_instr(w_instr)
  );

  typedef struct {
    logic        rst;
    logic        resp;
    logic [31:0] rdata;
    logic        stall;
    logic        flush;
    logic [31:0] redir;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        chk_id;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] W0 = 32'h00A0_0093;
  localparam logic [31:0] W1 = 32'h0010_0113;
  localparam logic [31:0] W2 = 32'h0020_0193;
  localparam logic [31:0] W3 = 32'hDEAD_BEEF;
  localparam logic [31:0] W4 = 32'h0030_0213;
  localparam logic [31:0] W5 = 32'h1111_1111;
  localparam logic [31:0] W6 = 32'h0040_0293;
  localparam logic [31:0] W7 = 32'h0050_0313;
  localparam logic [31:0] W8 = 32'h0060_0393;
  localparam logic [31:0] NOP = 32'h0000_0013;

  task automatic add(input logic r, input logic rs, input logic [31:0] rd, input logic st,
                     input logic fl, input logic [31:0] rp, input logic er, input logic [31:0] ea,
                     input logic ev, input logic ck, input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.resp = rs; v.rdata = rd; v.stall = st; v.flush = fl; v.redir = rp;
    v.e_read = er; v.e_addr = ea; v.e_valid = ev; v.chk_id = ck; v.e_pc = ep; v.e_instr = ei;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s row %0d: got %h want %h", name, row, got, want);
    end
  endtask

  initial begin
    //   rst resp rdata stall flush redir         read addr          valid chk pc            instr
    add(1, 0, 0,  0, 0, 0,             0, 32'h4000_0060, 0, 1, 32'h0,         NOP); // 0 reset
    add(0, 0, 0,  0, 0, 0,             1, 32'h4000_0060, 0, 1, 32'h0,         NOP);
    add(0, 1, W0, 0, 0, 0,             1, 32'h4000_0060, 0, 1, 32'h0,         NOP);
    add(0, 1, W0, 0, 0, 0,             1, 32'h4000_0064, 1, 1, 32'h4000_0060, W0);
    add(0, 1, W0, 0, 0, 0,             1, 32'h4000_0068, 1, 1, 32'h4000_0064, W0);
    add(0, 0, 0,  0, 0, 0,             1, 32'h4000_006C, 1, 1, 32'h4000_0068, W0); // 5
    add(0, 0, 0,  0, 0, 0,             1, 32'h4000_006C, 0, 0, 32'h0,         0);
    add(0, 1, W1, 1, 0, 0,             1, 32'h4000_006C, 0, 0, 32'h0,         0);
    add(0, 1, W2, 1, 0, 0,             1, 32'h4000_0070, 1, 1, 32'h4000_006C, W1);
    add(0, 0, 0,  1, 0, 0,             0, 32'h4000_0070, 1, 1, 32'h4000_006C, W1);
    add(0, 0, 0,  1, 0, 0,             0, 32'h4000_0070, 1, 1, 32'h4000_006C, W1); // 10
    add(0, 0, 0,  1, 0, 0,             0, 32'h4000_0070, 1, 1, 32'h4000_006C, W1);
    add(0, 0, 0,  0, 0, 0,             0, 32'h4000_0070, 1, 1, 32'h4000_006C, W1);
    add(0, 0, 0,  0, 0, 0,             1, 32'h4000_0074, 1, 1, 32'h4000_0070, W2);
    add(0, 0, 0,  0, 0, 0,             1, 32'h4000_0074, 0, 0, 32'h0,         0);
    add(1, 0, 0,  0, 0, 0,             0, 32'h4000_0074, 0, 0, 32'h0,         0);  // 15 re-reset
    add(0, 1, W0, 0, 0, 0,             1, 32'h4000_0060, 0, 1, 32'h0,         NOP);
    add(0, 1, W0, 0, 0, 0,             1, 32'h4000_0064, 1, 1, 32'h4000_0060, W0);
    add(0, 0, 0,  0, 0, 0,             1, 32'h4000_0068, 1, 1, 32'h4000_0064, W0);
    add(0, 0, 0,  0, 1, 32'h4000_1000, 1, 32'h4000_0068, 0, 0, 32'h0,         0);  // flush, read at 0068 open
    add(0, 0, 0,  0, 0, 0,             1, 32'h4000_0068, 0, 0, 32'h0,         0);  // 20 drain
    add(0, 1, W3, 0, 0, 0,             1, 32'h4000_0068, 0, 0, 32'h0,         0);
    add(0, 0, 0,  0, 0, 0,             1, 32'h4000_1000, 0, 0, 32'h0,         0);
    add(0, 1, W4, 0, 0, 0,             1, 32'h4000_1000, 0, 0, 32'h0,         0);
    add(0, 0, 0,  0, 0, 0,             1, 32'h4000_1004, 1, 1, 32'h4000_1000, W4);
    add(0, 1, W5, 0, 1, 32'h4000_2003, 1, 32'h4000_1004, 0, 0, 32'h0,         0);  // 25 flush with resp
    add(0, 0, 0,  0, 0, 0,             1, 32'h4000_2000, 0, 0, 32'h0,         0);
    add(0, 1, W6, 0, 0, 0,             1, 32'h4000_2000, 0, 0, 32'h0,         0);
    add(0, 1, W7, 1, 0, 0,             1, 32'h4000_2004, 1, 1, 32'h4000_2000, W6);
    add(0, 0, 0,  1, 0, 0,             0, 32'h4000_2004, 1, 1, 32'h4000_2000, W6);
    add(0, 0, 0,  1, 1, 32'h4000_3000, 0, 32'h4000_2004, 1, 1, 32'h4000_2000, W6); // 30 flush+stall, buf full
    add(0, 0, 0,  1, 0, 0,             1, 32'h4000_3000, 0, 0, 32'h0,         0);
    add(0, 1, W8, 0, 0, 0,             1, 32'h4000_3000, 0, 0, 32'h0,         0);
    add(0, 0, 0,  0, 0, 0,             1, 32'h4000_3004, 1, 1, 32'h4000_3000, W8);
    add(0, 0, 0,  0, 1, 32'h4000_4000, 1, 32'h4000_3004, 0, 0, 32'h0,         0);
    add(0, 0, 0,  0, 1, 32'h4000_5000, 1, 32'h4000_3004, 0, 0, 32'h0,         0);  // 35 flush in drain
    add(0, 1, W3, 0, 0, 0,             1, 32'h4000_3004, 0, 0, 32'h0,         0);
    add(0, 0, 0,  0, 0, 0,             1, 32'h4000_5000, 0, 0, 32'h0,         0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; imem_resp = vecs[i].resp; imem_rdata = vecs[i].rdata;
      stall_id = vecs[i].stall; flush = vecs[i].flush; redirect_pc = vecs[i].redir;
      #1;
      chk("imem_read", i, {31'h0, imem_read}, {31'h0, vecs[i].e_read});
      chk("imem_address", i, imem_address, vecs[i].e_addr);
      chk("id_valid", i, {31'h0, id_valid}, {31'h0, vecs[i].e_valid});
      if (vecs[i].chk_id) begin
        chk("id_pc", i, id_pc, vecs[i].e_pc);
        chk("id_instr", i, id_instr, vecs[i].e_instr);
      end
    end

    // PC wrap from the top of the address space.
    @(negedge clk);
    rst = 1'b1; imem_resp = 1'b0; flush = 1'b0; stall_id = 1'b0; redirect_pc = 32'h0;
    #1;
    chk("wrap_read_in_reset", 100, {31'h0, w_read}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("wrap_first_read", 101, {31'h0, w_read}, 32'h1);
    chk("wrap_first_addr", 101, w_address, 32'hFFFF_FFFC);
    @(negedge clk);
    imem_resp = 1'b1; imem_rdata = W0;
    #1;
    chk("wrap_hold_addr", 102, w_address, 32'hFFFF_FFFC);
    @(negedge clk);
    imem_resp = 1'b0;
    #1;
    chk("wrap_second_addr", 103, w_address, 32'h0000_0000);
    chk("wrap_id_valid", 103, {31'h0, w_valid}, 32'h1);
    chk("wrap_id_pc", 103, w_pc, 32'hFFFF_FFFC);
    chk("wrap_id_instr", 103, w_instr, W0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
